// File: rtl/exp_bias_normalize.sv
// Exponent stage of the FP multiplier: removes one bias from the registered
// exponent sum, applies the mantissa normalisation increment, saturates to
// the exponent field and raises overflow/underflow flags.
module exp_bias_normalize #(
   parameter int unsigned W_Exp = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [W_Exp:0]   Exp_Add,
   input  logic             underflow_f,
   input  logic             norm_valid,
   input  logic             norm_shift,
   output logic [W_Exp-1:0] Exp_Res,
   output logic             overflow_flag,
   output logic             underflow_flag,
   output logic             busy,
   output logic             done
);

   localparam int unsigned W_SUM    = W_Exp + 1;
   localparam int unsigned W_ADJ    = W_Exp + 2;
   localparam int unsigned BIAS_VAL = (2 ** (W_Exp - 1)) - 1;
   localparam int unsigned EXP_MAX  = (2 ** W_Exp) - 1;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      BIAS      = 3'd1,
      WAIT_NORM = 3'd2,
      ADJUST    = 3'd3,
      DONE      = 3'd4
   } state_t;

   state_t             state, state_d;
   logic [W_SUM-1:0]   exp_reg, exp_d;
   logic [W_SUM-1:0]   diff_reg, diff_d;
   logic               shift_reg, shift_d;
   logic [W_Exp-1:0]   res_d;
   logic               ov_d, un_d;
   logic [W_ADJ-1:0]   adj_c;

   // Unbiased exponent plus the normalisation increment
   assign adj_c = W_ADJ'(diff_reg) + W_ADJ'(shift_reg);

   // Next-state and next-value logic; results only change on entry to DONE
   always_comb begin
      state_d = state;
      exp_d   = exp_reg;
      diff_d  = diff_reg;
      shift_d = shift_reg;
      res_d   = Exp_Res;
      ov_d    = overflow_flag;
      un_d    = underflow_flag;
      case (state)
         IDLE: begin
            if (start) begin
               if (underflow_f) begin
                  state_d = DONE;
                  res_d   = '0;
                  ov_d    = 1'b0;
                  un_d    = 1'b1;
               end else begin
                  state_d = BIAS;
                  exp_d   = Exp_Add;
               end
            end
         end
         BIAS: begin
            // underflow_f=0 guarantees the sum is at least one bias
            diff_d  = exp_reg - W_SUM'(BIAS_VAL);
            state_d = WAIT_NORM;
         end
         WAIT_NORM: begin
            if (norm_valid) begin
               shift_d = norm_shift;
               state_d = ADJUST;
            end
         end
         ADJUST: begin
            state_d = DONE;
            if (adj_c >= W_ADJ'(EXP_MAX)) begin
               res_d = '1;
               ov_d  = 1'b1;
               un_d  = 1'b0;
            end else if (adj_c == '0) begin
               res_d = '0;
               ov_d  = 1'b0;
               un_d  = 1'b1;
            end else begin
               res_d = adj_c[W_Exp-1:0];
               ov_d  = 1'b0;
               un_d  = 1'b0;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, datapath and registered outputs with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= IDLE;
         exp_reg        <= '0;
         diff_reg       <= '0;
         shift_reg      <= 1'b0;
         Exp_Res        <= '0;
         overflow_flag  <= 1'b0;
         underflow_flag <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
      end else begin
         state          <= state_d;
         exp_reg        <= exp_d;
         diff_reg       <= diff_d;
         shift_reg      <= shift_d;
         Exp_Res        <= res_d;
         overflow_flag  <= ov_d;
         underflow_flag <= un_d;
         busy           <= (state_d != IDLE);
         done           <= (state_d == DONE);
      end
   end

endmodule

// File: tb/tb_exp_bias_normalize.sv
// Directed bench for exp_bias_normalize: single and double precision widths.
module tb_exp_bias_normalize;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [8:0]  exp_add8;
   logic [11:0] exp_add11;
   logic        underflow_f;
   logic        norm_valid;
   logic        norm_shift;
   logic [7:0]  res8;
   logic [10:0] res11;
   logic        ov8, un8, busy8, done8;
   logic        ov11, un11, busy11, done11;

   int total = 0;
   int bad   = 0;

   exp_bias_normalize #(.W_Exp(8)) dut8 (
      .clk(clk), .rst(rst), .start(start), .Exp_Add(exp_add8),
      .underflow_f(underflow_f), .norm_valid(norm_valid), .norm_shift(norm_shift),
      .Exp_Res(res8), .overflow_flag(ov8), .underflow_flag(un8),
      .busy(busy8), .done(done8)
   );

   exp_bias_normalize #(.W_Exp(11)) dut11 (
      .clk(clk), .rst(rst), .start(start), .Exp_Add(exp_add11),
      .underflow_f(underflow_f), .norm_valid(norm_valid), .norm_shift(norm_shift),
      .Exp_Res(res11), .overflow_flag(ov11), .underflow_flag(un11),
      .busy(busy11), .done(done11)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One operation on the selected width; norm_valid is first seen at edge N+nv_first
   task automatic run_op(input int sel, input int unsigned ea, input logic uf,
                         input logic sh, input int nv_first, input int exp_lat,
                         input int unsigned exp_res, input logic exp_ov,
                         input logic exp_un, input logic poke, input string name);
      int unsigned prev, r;
      logic d, b, o, u;
      int cnt;
      prev = (sel == 11) ? 32'(res11) : 32'(res8);
      start       = 1'b1;
      exp_add8    = 9'(ea);
      exp_add11   = 12'(ea);
      underflow_f = uf;
      norm_shift  = sh;
      norm_valid  = (nv_first == 0);
      tick();
      start = 1'b0;
      cnt = 0;
      d = (sel == 11) ? done11 : done8;
      while (!d && cnt < 30) begin
         b = (sel == 11) ? busy11 : busy8;
         r = (sel == 11) ? 32'(res11) : 32'(res8);
         total++;
         if (b !== 1'b1) begin
            bad++;
            $display("FAIL %s busy cycle %0d: got %b want 1", name, cnt, b);
         end
         total++;
         if (r !== prev) begin
            bad++;
            $display("FAIL %s hold cycle %0d: got %0d want %0d", name, cnt, r, prev);
         end
         if (poke) begin
            start       = 1'b1;
            exp_add8    = 9'(cnt * 37 + 5);
            exp_add11   = 12'(cnt * 37 + 5);
            underflow_f = cnt[0];
         end
         norm_valid = (cnt + 1 >= nv_first);
         tick();
         cnt++;
         d = (sel == 11) ? done11 : done8;
      end
      start       = 1'b0;
      underflow_f = 1'b0;
      r = (sel == 11) ? 32'(res11) : 32'(res8);
      o = (sel == 11) ? ov11 : ov8;
      u = (sel == 11) ? un11 : un8;
      b = (sel == 11) ? busy11 : busy8;
      total++;
      if (cnt !== exp_lat || !d) begin
         bad++;
         $display("FAIL %s latency: got %0d done=%b want %0d", name, cnt, d, exp_lat);
      end
      total++;
      if (r !== exp_res) begin
         bad++;
         $display("FAIL %s Exp_Res: got %0d want %0d", name, r, exp_res);
      end
      total++;
      if (o !== exp_ov || u !== exp_un) begin
         bad++;
         $display("FAIL %s flags: got ov=%b un=%b want ov=%b un=%b", name, o, u, exp_ov, exp_un);
      end
      total++;
      if (b !== 1'b1) begin
         bad++;
         $display("FAIL %s busy in done: got %b want 1", name, b);
      end
      norm_valid = 1'b0;
      tick();
      d = (sel == 11) ? done11 : done8;
      b = (sel == 11) ? busy11 : busy8;
      r = (sel == 11) ? 32'(res11) : 32'(res8);
      total++;
      if (d !== 1'b0 || b !== 1'b0 || r !== exp_res) begin
         bad++;
         $display("FAIL %s after done: got done=%b busy=%b res=%0d want 0 0 %0d",
                  name, d, b, r, exp_res);
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         total++;
         if ({res8, ov8, un8, busy8, done8} !== 12'h0 ||
             {res11, ov11, un11, busy11, done11} !== 15'h0) begin
            bad++;
            $display("FAIL reset_state %0d: got %h %h want 0 0", i,
                     {res8, ov8, un8, busy8, done8}, {res11, ov11, un11, busy11, done11});
         end
         tick();
      end
   endtask

   task automatic test_basic();
      run_op(8, 254, 1'b0, 1'b0, 0, 3, 127, 1'b0, 1'b0, 1'b0, "basic_254");
   endtask

   task automatic test_overflow();
      run_op(8, 381, 1'b0, 1'b1, 0, 3, 255, 1'b1, 1'b0, 1'b0, "ovf_381");
      run_op(8, 380, 1'b0, 1'b0, 0, 3, 253, 1'b0, 1'b0, 1'b0, "near_380");
   endtask

   task automatic test_underflow();
      run_op(8, 100, 1'b1, 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b0, "uf_path");
      run_op(8, 127, 1'b0, 1'b0, 0, 3, 0, 1'b0, 1'b1, 1'b0, "zero_127");
      run_op(8, 127, 1'b0, 1'b1, 0, 3, 1, 1'b0, 1'b0, 1'b0, "one_127");
   endtask

   task automatic test_delayed_norm();
      run_op(8, 254, 1'b0, 1'b0, 7, 8, 127, 1'b0, 1'b0, 1'b1, "late_norm");
   endtask

   task automatic test_mid_reset();
      run_op(8, 381, 1'b0, 1'b1, 0, 3, 255, 1'b1, 1'b0, 1'b0, "pre_reset");
      start       = 1'b1;
      exp_add8    = 9'd200;
      exp_add11   = 12'd200;
      underflow_f = 1'b0;
      norm_valid  = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      total++;
      if (busy8 !== 1'b1) begin
         bad++;
         $display("FAIL mid_reset busy before: got %b want 1", busy8);
      end
      rst = 1'b0;
      tick();
      rst = 1'b1;
      total++;
      if ({res8, ov8, un8, busy8, done8} !== 12'h0) begin
         bad++;
         $display("FAIL mid_reset state: got %h want 0", {res8, ov8, un8, busy8, done8});
      end
      norm_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         total++;
         if (done8 !== 1'b0 || busy8 !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset no_done %0d: got done=%b busy=%b want 0 0", i, done8, busy8);
         end
      end
      norm_valid = 1'b0;
      run_op(8, 300, 1'b0, 1'b0, 0, 3, 173, 1'b0, 1'b0, 1'b0, "post_reset_300");
   endtask

   task automatic test_wide();
      run_op(11, 2046, 1'b0, 1'b1, 0, 3, 1024, 1'b0, 1'b0, 1'b0, "dbl_2046");
      run_op(11, 3069, 1'b0, 1'b1, 0, 3, 2047, 1'b1, 1'b0, 1'b0, "dbl_ovf_3069");
   endtask

   initial begin
      rst         = 1'b0;
      start       = 1'b0;
      exp_add8    = '0;
      exp_add11   = '0;
      underflow_f = 1'b0;
      norm_valid  = 1'b0;
      norm_shift  = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      test_reset();
      test_basic();
      test_overflow();
      test_underflow();
      test_delayed_norm();
      test_mid_reset();
      test_wide();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exp_bias_normalize.md
# exp_bias_normalize

Tenth-phase exponent stage of the floating-point multiplier. It consumes the registered biased exponent sum and underflow flag from the exponent-add phase, removes one bias and applies the mantissa-normalisation increment. It then saturates to the IEEE-754 exponent field and raises overflow/underflow flags. A small FSM sequences the work and waits on the mantissa path before finalising.

## Interface
- W_Exp, 8, exponent field width (8 single, 11 double); Bias = 2^(W_Exp-1)-1 (127 / 1023)
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; synchronous, active-low (rst==0 at a rising edge resets)
- start  in  1  request; sampled only in IDLE
- Exp_Add  in  W_Exp+1  biased sum Exp_X+Exp_Y from the previous phase; captured on accepted start
- underflow_f  in  1  previous-phase underflow flag (Exp_Add < Bias); captured on accepted start
- norm_valid  in  1  mantissa product normalisation info valid
- norm_shift  in  1  mantissa product MSB set, exponent needs +1; sampled with norm_valid
- Exp_Res  out  W_Exp  final exponent field
- overflow_flag  out  1  result exponent saturated to all-ones
- underflow_flag  out  1  result exponent forced to zero
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse, outputs valid

## Operation
- States: IDLE, BIAS, WAIT_NORM, ADJUST, DONE.
- IDLE:
  - start=1 and underflow_f=1 -> DONE, loading Exp_Res=0, underflow_flag=1, overflow_flag=0.
  - start=1 and underflow_f=0 -> BIAS, capturing Exp_Add into an internal register.
  - Otherwise stay in IDLE.
- BIAS: diff = Exp_Add_reg - Bias, W_Exp+1 bits unsigned (never negative, guaranteed by underflow_f=0) -> WAIT_NORM.
- WAIT_NORM: hold until norm_valid=1, then capture norm_shift -> ADJUST. No timeout.
- ADJUST: adj = diff + norm_shift, W_Exp+2 bits. The result is loaded at the edge into DONE:
  - adj >= 2^W_Exp-1 -> Exp_Res=all ones, overflow_flag=1, underflow_flag=0.
  - adj == 0 -> Exp_Res=0, underflow_flag=1, overflow_flag=0.
  - Otherwise Exp_Res=adj[W_Exp-1:0], both flags 0.
- DONE: done=1 for this single cycle -> IDLE unconditionally.
- Exp_Res and both flags change only on entry to DONE. They hold their value through later IDLE/BIAS/WAIT_NORM/ADJUST until the next DONE.
- start outside IDLE is ignored, with no queuing.
- norm_valid outside WAIT_NORM is ignored.

## Timing
- Reset (rst=0 at an edge): state=IDLE; Exp_Res=0, overflow_flag=0, underflow_flag=0, busy=0, done=0; internal registers cleared. Reset overrides every transition, including mid-operation; an aborted operation produces no done.
- Normal path, start sampled at edge N, norm_valid already high: BIAS after N, WAIT_NORM after N+1, ADJUST after N+2, DONE after N+3. Outputs valid and done=1 in the cycle between N+3 and N+4; back in IDLE after N+4.
- Each cycle norm_valid is late adds exactly one cycle of latency.
- Underflow path: DONE after edge N; done=1 between N and N+1.
- busy is registered from state: high the cycle after an accepted start, low once back in IDLE.
- A new start may be accepted at the edge that leaves DONE? No — it is accepted only while in IDLE, so minimum issue interval is 5 cycles (normal) or 2 cycles (underflow).

## Test plan
- W_Exp=8, Exp_Add=254, underflow_f=0, norm_valid held 1, norm_shift=0 -> done 4 cycles after start, Exp_Res=127, both flags 0.
- W_Exp=8, Exp_Add=381, norm_shift=1 -> Exp_Res=255, overflow_flag=1. Then Exp_Add=380, norm_shift=0 -> Exp_Res=253, flags 0.
- W_Exp=8, underflow_f=1, Exp_Add=100 -> done 1 cycle after start, Exp_Res=0, underflow_flag=1. Then Exp_Add=127, norm_shift=0 -> Exp_Res=0, underflow_flag=1; with norm_shift=1 -> Exp_Res=1, flags 0.
- norm_valid delayed 6 cycles after start -> busy stays high and done arrives 9 cycles after start. Pulses on start during busy change nothing; Exp_Res keeps its previous value until DONE.
- rst=0 while in WAIT_NORM -> next cycle busy=0, Exp_Res=0, flags 0, no done pulse. A subsequent start with Exp_Add=300, norm_shift=0 gives Exp_Res=173.
- W_Exp=11, Exp_Add=2046, norm_shift=1 -> Exp_Res=1024. Exp_Add=3069, norm_shift=1 -> Exp_Res=2047, overflow_flag=1.
